pwm16_gen: RTL and testbench
============================

# pwm16_gen

Edge-aligned PWM generator directly downstream of the 16-bit error-feedback quantizer. Accepts one quantized duty word per PWM period over a valid/ready handshake, holds it in a shadow register, and applies it glitch-free at the next period boundary. The quantizer advances its error state only on an accepted handshake, so exactly one quantizer step is consumed per PWM period. Missing samples repeat the previous duty and raise a sticky underrun flag.

## Interface
- `W`, default 16: counter and duty width; the PWM period is 2^W clocks.
- `ACTIVE_HIGH`, default 1: when 0, `pwm_out` is inverted. This includes the idle level.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run enable. Low forces the IDLE state.
- `duty_in` in W: duty word from the quantizer (`quant`).
- `duty_valid` in 1: `duty_in` is valid.
- `duty_ready` out 1: shadow register is empty and can accept a word.
- `clr_underrun` in 1: one-cycle pulse that clears `underrun`.
- `pwm_out` out 1: PWM output (registered).
- `period_start` out 1: one-cycle strobe on the first cycle of each period (registered).
- `underrun` out 1: sticky flag, set when a period boundary found no new sample.
- `duty_active` out W: duty currently being output (for observation).

## Operation
- **States:**
  - IDLE: counter held at 0; `pwm_out` at the inactive level.
  - RUN: counter free-runs from 0 to 2^W−1 and wraps.
  - IDLE→RUN on `en`=1. RUN→IDLE on `en`=0 in any cycle, taking effect next cycle; the current period is abandoned.
- **Handshake:**
  - A word is accepted when `duty_valid && duty_ready`.
  - `duty_ready` = shadow empty; it is a registered flag with no combinational path from `duty_valid`.
  - Accepted words are written into the shadow register, which is then marked full. The handshake operates in both states.
- **Load point:** the load point is the first cycle of every period, and also the IDLE→RUN entry.
  - If the shadow is full: `duty_active` ← shadow and the shadow is marked empty.
  - Otherwise `duty_active` is unchanged and `underrun` is set. Exception: no underrun is raised at IDLE→RUN entry.
- **Bypass:** a word accepted in the cycle immediately before a load point is loaded directly at that load point. It does not count as an underrun and leaves the shadow empty.
- **Compare:**
  - Within a period, `pwm_out` is active for the first `duty_active` cycles, then inactive for the remainder.
  - Duty 0 means never active. Duty 2^W−1 means inactive only in the last cycle. 100% duty cannot be produced.
- **Underrun flag:**
  - `clr_underrun` clears the flag.
  - If clear and set occur in the same cycle, set wins.
- **Reset values:** state IDLE; counter 0; `duty_active` 0; shadow empty; `duty_ready` 1; `underrun` 0; `period_start` 0; `pwm_out` inactive (0 when `ACTIVE_HIGH`=1).
- **Reset mid-period:** everything returns to the reset values on the next edge, and any shadowed word is discarded.

## Timing
- `pwm_out` and `period_start` are registered and aligned: the first active cycle of a period coincides with `period_start`=1.
- From the `en` rising edge to the first `period_start`: 1 cycle.
- From the `en` falling edge to `pwm_out` reaching the inactive level: 1 cycle.
- After a load point consumes the shadow, `duty_ready` rises 1 cycle later.
- Throughput: at most one word per 2^W cycles in steady state, plus the shadow depth of 1.
- A word accepted at or after the load cycle waits for the next period.

## Structure
- Shared package `pwm_pkg` holds:
  - the state enum (IDLE, RUN);
  - the default `W`;
  - the inactive-level helper constant used by other PWM-side blocks.
- Natural sub-module: `duty_shadow`, a one-entry skid register with valid/ready and a load/consume port. It is reused by future multi-channel outputs.
- Top-level logic: counter, state machine, load-point logic, comparator, and flag.

## Test plan
All scenarios run with `W`=4 (period 16 clocks) and `ACTIVE_HIGH`=1.
- **Reset and start:** reset, then `en`=1 with `duty_in`=5 offered beforehand → word accepted in IDLE; on `en`, `period_start` pulses; `pwm_out` high for 5 cycles, low for 11; `underrun`=0.
- **Extremes:** duty 0 → `pwm_out` never high for a whole period. Duty 15 → high for 15 cycles, low for 1, repeating every 16.
- **Underrun:** after one period of duty 7, supply no word → `underrun`=1 at the next `period_start` and duty 7 repeats. Pulse `clr_underrun` → flag clears. Set and clear in the same cycle → flag stays 1.
- **Bypass edge:** word 9 accepted in the cycle before the boundary → the next period outputs 9 high cycles, with no underrun and `duty_ready`=1 afterwards. Word accepted in the boundary cycle itself → applied only one period later.
- **Back-pressure:** `duty_valid` held high with words 1,2,3… → exactly one accept per 16 cycles, `duty_ready` low between accepts, and the output duty sequence matches the accepted words in order.
- **Mid-period disable and reset:** `en` drops at count 3 → `pwm_out`=0 the next cycle and the counter holds 0. `rst` pulsed mid-period with the shadow full → all outputs return to their reset values and the shadowed word is lost.

Source files
------------

// File: rtl/pwm16_gen_pkg.sv
// Shared PWM-side definitions: state encoding, default width, inactive-level helper.
package pwm_pkg;

  localparam int unsigned DefaultW = 16;

  typedef enum logic {StIdle, StRun} pwm_state_e;

  // Output level that means "off" for a given polarity.
  function automatic logic inactive_level(input bit active_high);
    return ~active_high;
  endfunction

endpackage

// File: rtl/pwm16_gen_if.sv
// Duty-word valid/ready channel from the quantizer into the PWM block.
interface pwm16_gen_if
  import pwm_pkg::*;
#(
  parameter int unsigned W = DefaultW
) ();

  logic [W-1:0] duty_in;
  logic         duty_valid;
  logic         duty_ready;

  modport master (output duty_in, output duty_valid, input duty_ready);
  modport slave  (input duty_in, input duty_valid, output duty_ready);

endinterface

// File: rtl/pwm16_gen_duty_shadow.sv
// One-entry shadow register: accepts a word when empty, emptied by a consume pulse.
module duty_shadow #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] wr_data_i,
  input  logic         wr_valid_i,
  output logic         wr_ready_o,
  output logic         accept_o,
  input  logic         consume_i,
  output logic         rd_valid_o,
  output logic [W-1:0] rd_data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  assign wr_ready_o = ~full_q;
  assign accept_o   = wr_valid_i & ~full_q;
  assign rd_valid_o = full_q;
  assign rd_data_o  = data_q;

  // A consume while empty with a concurrent accept is a bypass: the word is not stored.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (consume_i) begin
      full_d = 1'b0;
    end else if (accept_o) begin
      full_d = 1'b1;
      data_d = wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/pwm16_gen.sv
// Edge-aligned PWM with a shadowed duty word applied at each period boundary.
module pwm16_gen
  import pwm_pkg::*;
#(
  parameter int unsigned W           = DefaultW,
  parameter bit          ACTIVE_HIGH = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  pwm16_gen_if.slave    duty_if,
  input  logic          clr_underrun,
  output logic          pwm_out,
  output logic          period_start,
  output logic          underrun,
  output logic [W-1:0]  duty_active
);

  localparam logic         InactLvl = inactive_level(ACTIVE_HIGH);
  localparam logic [W-1:0] CntMax   = '1;

  pwm_state_e   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d, duty_q, duty_d;
  logic         pwm_q, pwm_d, start_q, start_d, unr_q, unr_d;
  logic         load, entry, set_unr, run_d;
  logic         sh_valid, sh_accept, sh_ready;
  logic [W-1:0] sh_data;

  duty_shadow #(
    .W(W)
  ) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .wr_data_i  (duty_if.duty_in),
    .wr_valid_i (duty_if.duty_valid),
    .wr_ready_o (sh_ready),
    .accept_o   (sh_accept),
    .consume_i  (load),
    .rd_valid_o (sh_valid),
    .rd_data_o  (sh_data)
  );

  assign duty_if.duty_ready = sh_ready;

  // Load happens on the edge that starts a period, so the new duty is live in its first cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    entry   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (en) begin
          state_d = StRun;
          entry   = 1'b1;
          load    = 1'b1;
        end
      end
      StRun: begin
        if (!en) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + W'(1);
          load  = (cnt_q == CntMax);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    duty_d  = duty_q;
    set_unr = 1'b0;
    if (load) begin
      if (sh_valid) begin
        duty_d = sh_data;
      end else if (sh_accept) begin
        duty_d = duty_if.duty_in;
      end else if (!entry) begin
        set_unr = 1'b1;
      end
    end
    unr_d   = set_unr ? 1'b1 : (clr_underrun ? 1'b0 : unr_q);
    run_d   = (state_d == StRun);
    pwm_d   = (run_d && (cnt_d < duty_d)) ? ~InactLvl : InactLvl;
    start_d = run_d && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      duty_q  <= '0;
      pwm_q   <= InactLvl;
      start_q <= 1'b0;
      unr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      start_q <= start_d;
      unr_q   <= unr_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = start_q;
  assign underrun     = unr_q;
  assign duty_active  = duty_q;

endmodule

// File: tb/tb_pwm16_gen.sv
// Directed bench for pwm16_gen with W=4 (16-clock period), active-high output.
module tb_pwm16_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clr_underrun = 1'b0;
  logic       pwm_out, period_start, underrun;
  logic [3:0] duty_active;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  pwm16_gen_if #(.W(4)) duty_if ();

  pwm16_gen #(
    .W           (4),
    .ACTIVE_HIGH (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .duty_if      (duty_if),
    .clr_underrun (clr_underrun),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .underrun     (underrun),
    .duty_active  (duty_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pwm"}, pwm_out, 0);
    check_eq({tag, "_start"}, period_start, 0);
    check_eq({tag, "_unr"}, underrun, 0);
    check_eq({tag, "_dact"}, duty_active, 0);
    check_eq({tag, "_ready"}, duty_if.duty_ready, 1);
  endtask

  // Called on the first cycle of a period; returns on the first cycle of the next one.
  task automatic run_period(input int d, input bit unr0, input int off, input int w,
                            input int clr_at);
    bit u;
    u = unr0;
    for (int i = 0; i < 16; i++) begin
      check_eq("start", period_start, (i == 0));
      check_eq("pwm", pwm_out, (i < d));
      check_eq("dact", duty_active, d);
      check_eq("unr", underrun, u);
      if (i == off) begin
        duty_if.duty_valid = 1'b1;
        duty_if.duty_in    = 4'(w);
      end
      if (i == clr_at) clr_underrun = 1'b1;
      tick();
      duty_if.duty_valid = 1'b0;
      clr_underrun       = 1'b0;
      if (i == clr_at) u = 1'b0;
    end
  endtask

  initial begin
    int nacc;
    int exp_d;
    bit acc;
    duty_if.duty_valid = 1'b0;
    duty_if.duty_in    = '0;

    tick();
    tick();
    check_reset_vals("rst");
    rst = 1'b0;

    // Word offered while idle is shadowed, then loaded at run entry.
    check_eq("idle_ready", duty_if.duty_ready, 1);
    duty_if.duty_valid = 1'b1;
    duty_if.duty_in    = 4'd5;
    tick();
    duty_if.duty_valid = 1'b0;
    check_eq("idle_full", duty_if.duty_ready, 0);
    check_eq("idle_pwm", pwm_out, 0);
    check_eq("idle_start", period_start, 0);
    en = 1'b1;
    tick();

    run_period(5, 0, 15, 0, -1);    // bypass 0 into next period
    run_period(0, 0, 15, 15, -1);   // bypass 15
    run_period(15, 0, 3, 7, -1);    // 7 shadowed mid-period
    run_period(7, 0, -1, 0, -1);    // nothing supplied
    run_period(7, 1, -1, 0, 4);     // underrun seen, then cleared
    run_period(7, 1, -1, 0, 15);    // clear collides with set at boundary
    run_period(7, 1, 15, 9, 1);     // bypass 9 in the last cycle
    check_eq("ready_after_bypass", duty_if.duty_ready, 1);
    run_period(9, 0, 0, 2, -1);     // 2 accepted in boundary cycle
    run_period(2, 0, -1, 0, -1);

    // Back-pressure: valid held high with increasing words.
    nacc = 0;
    duty_if.duty_valid = 1'b1;
    duty_if.duty_in    = 4'd1;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 16; i++) begin
        exp_d = (p == 0) ? 2 : p;
        check_eq("bp_ready", duty_if.duty_ready, (i == 0));
        check_eq("bp_pwm", pwm_out, (i < exp_d));
        check_eq("bp_dact", duty_active, exp_d);
        acc = duty_if.duty_ready;
        tick();
        if (acc) begin
          nacc++;
          duty_if.duty_in = duty_if.duty_in + 4'd1;
        end
      end
    end
    duty_if.duty_valid = 1'b0;
    check_eq("bp_accepts", nacc, 4);

    // Mid-period disable at count 3 (duty 4 would still be high).
    tick();
    tick();
    tick();
    check_eq("dis_pre_pwm", pwm_out, 1);
    en = 1'b0;
    tick();
    check_eq("dis_pwm", pwm_out, 0);
    check_eq("dis_start", period_start, 0);
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    check_eq("dis_unr_clr", underrun, 0);
    check_eq("dis_pwm2", pwm_out, 0);
    en = 1'b1;
    tick();
    check_eq("reen_start", period_start, 1);
    check_eq("reen_pwm", pwm_out, 1);
    check_eq("reen_dact", duty_active, 4);
    check_eq("reen_unr", underrun, 0);

    // Reset mid-period with the shadow full; shadowed 11 must be lost.
    duty_if.duty_valid = 1'b1;
    duty_if.duty_in    = 4'd11;
    tick();
    duty_if.duty_valid = 1'b0;
    check_eq("pre_rst_full", duty_if.duty_ready, 0);
    tick();
    tick();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    rst = 1'b0;
    check_reset_vals("midrst");
    en = 1'b1;
    tick();
    run_period(0, 0, -1, 0, -1);
    run_period(0, 1, -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
